// File: rtl/mat_mem_arbiter.sv
// Single-port data memory arbiter for host, operand fetch and result writeback.
// Optional build macro MAT_ARB_STARVE_GUARD_EN adds a host starvation guard.
module mat_mem_arbiter #(
    parameter int                   ADDR_SIZE       = 10,
    parameter int                   DATA_SIZE       = 8,
    parameter logic [ADDR_SIZE-1:0] ZERO_POINT_ADDR = '1,
    parameter int                   MAX_WAIT        = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [DATA_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [DATA_SIZE-1:0] host_rdata,
    input  logic                 fch_req,
    input  logic [ADDR_SIZE-1:0] fch_addr,
    output logic                 fch_gnt,
    output logic                 fch_rvalid,
    output logic [DATA_SIZE-1:0] fch_rdata,
    input  logic                 wb_req,
    input  logic [ADDR_SIZE-1:0] wb_addr,
    input  logic [DATA_SIZE-1:0] wb_wdata,
    output logic                 wb_gnt,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_FCH  = 2'd2
    } owner_e;

    // A zero-point fetch can share a return cycle with a host read, so it is a separate flag.
    typedef struct packed {
        owner_e owner;
        logic   zero;
    } tag_t;

    logic                 rr_host;
    logic                 zero_fch;
    logic                 mem_fch_req;
    logic                 host_urgent;
    logic                 grant_host;
    logic                 grant_fch_mem;
    logic                 grant_wb;
    logic                 mem_en_q;
    logic                 mem_we_q;
    logic [ADDR_SIZE-1:0] mem_addr_q;
    logic [DATA_SIZE-1:0] mem_wdata_q;
    tag_t                 tag_s1;
    tag_t                 tag_s2;
    tag_t                 tag_next;

    assign zero_fch    = fch_req && (fch_addr == ZERO_POINT_ADDR);
    assign mem_fch_req = fch_req && !zero_fch;

`ifdef MAT_ARB_STARVE_GUARD_EN
    localparam int                CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (reset || !host_req || grant_host) begin
            starve_cnt <= '0;
        end else if (starve_cnt != WAIT_LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign host_urgent = (starve_cnt == WAIT_LIMIT);
`else
    assign host_urgent = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant_host    = 1'b0;
        grant_fch_mem = 1'b0;
        grant_wb      = 1'b0;
        if (reset) begin
            grant_host = 1'b0;
        end else if (host_req && host_urgent) begin
            grant_host = 1'b1;
        end else if (wb_req) begin
            grant_wb = 1'b1;
        end else if (host_req && mem_fch_req) begin
            grant_host    = rr_host;
            grant_fch_mem = !rr_host;
        end else if (host_req) begin
            grant_host = 1'b1;
        end else if (mem_fch_req) begin
            grant_fch_mem = 1'b1;
        end
    end

    assign host_gnt = grant_host;
    assign wb_gnt   = grant_wb;
    assign fch_gnt  = !reset && (grant_fch_mem || zero_fch);

    always_comb begin
        tag_next.owner = OWN_NONE;
        tag_next.zero  = zero_fch && !reset;
        if (grant_host && !host_we) begin
            tag_next.owner = OWN_HOST;
        end else if (grant_fch_mem) begin
            tag_next.owner = OWN_FCH;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_host     <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_s1      <= '0;
            tag_s2      <= '0;
        end else begin
            if (grant_host) begin
                rr_host <= 1'b0;
            end else if (grant_fch_mem) begin
                rr_host <= 1'b1;
            end

            mem_en_q    <= grant_host || grant_fch_mem || grant_wb;
            mem_we_q    <= grant_wb || (grant_host && host_we);
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if (grant_wb) begin
                mem_addr_q  <= wb_addr;
                mem_wdata_q <= wb_wdata;
            end else if (grant_host) begin
                mem_addr_q  <= host_addr;
                mem_wdata_q <= host_we ? host_wdata : '0;
            end else if (grant_fch_mem) begin
                mem_addr_q  <= fch_addr;
            end

            tag_s1 <= tag_next;
            tag_s2 <= tag_s1;
        end
    end

    // Registered command is masked while reset is held so the port reads idle immediately.
    assign mem_en    = mem_en_q && !reset;
    assign mem_we    = mem_en && mem_we_q;
    assign mem_addr  = mem_en ? mem_addr_q : '0;
    assign mem_wdata = mem_en ? mem_wdata_q : '0;

    assign host_rvalid = !reset && (tag_s2.owner == OWN_HOST);
    assign host_rdata  = host_rvalid ? mem_rdata : '0;
    assign fch_rvalid  = !reset && ((tag_s2.owner == OWN_FCH) || tag_s2.zero);
    assign fch_rdata   = (!reset && (tag_s2.owner == OWN_FCH)) ? mem_rdata : '0;

    assign busy = !reset && ((tag_s1 != '0) || (tag_s2 != '0));

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// Directed bench for mat_mem_arbiter with a behavioural memory and a return scoreboard.
// Guard expectations follow MAT_ARB_STARVE_GUARD_EN.
module tb_mat_mem_arbiter;

    localparam logic [9:0] ZP = 10'h3FF;

    logic       clk;
    logic       reset;
    logic       host_req, host_we, host_gnt, host_rvalid;
    logic [9:0] host_addr;
    logic [7:0] host_wdata, host_rdata;
    logic       fch_req, fch_gnt, fch_rvalid;
    logic [9:0] fch_addr;
    logic [7:0] fch_rdata;
    logic       wb_req, wb_gnt;
    logic [9:0] wb_addr;
    logic [7:0] wb_wdata;
    logic       mem_en, mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       busy;

    mat_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .fch_req    (fch_req),
        .fch_addr   (fch_addr),
        .fch_gnt    (fch_gnt),
        .fch_rvalid (fch_rvalid),
        .fch_rdata  (fch_rdata),
        .wb_req     (wb_req),
        .wb_addr    (wb_addr),
        .wb_wdata   (wb_wdata),
        .wb_gnt     (wb_gnt),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Memory macro model: read data valid the cycle after the command.
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        int         due;
        logic       host;
        logic [7:0] data;
    } ret_t;

    ret_t       ret_q[$];
    logic [7:0] shadow [1024];
    logic [19:0] prev_cmd;
    int         cycle;
    int         total;
    int         bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic step(input logic rst,
                        input logic h_req, input logic h_we, input logic [9:0] h_addr, input logic [7:0] h_wdata,
                        input logic f_req, input logic [9:0] f_addr,
                        input logic w_req, input logic [9:0] w_addr, input logic [7:0] w_wdata,
                        input logic e_hg, input logic e_fg, input logic e_wg);
        logic [8:0]  exp_h, exp_f;
        logic        popped;
        logic [19:0] cmd;
        ret_t        r;
        reset = rst;
        host_req = h_req; host_we = h_we; host_addr = h_addr; host_wdata = h_wdata;
        fch_req = f_req; fch_addr = f_addr;
        wb_req = w_req; wb_addr = w_addr; wb_wdata = w_wdata;
        @(negedge clk);
        if (rst) begin
            check("reset_ctl", {60'd0, host_gnt, fch_gnt, wb_gnt, busy}, 64'd0);
            check("reset_data", {host_rvalid, host_rdata, fch_rvalid, fch_rdata,
                                 mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
            ret_q.delete();
            prev_cmd = '0;
        end else begin
            check("grants", {61'd0, host_gnt, fch_gnt, wb_gnt}, {61'd0, e_hg, e_fg, e_wg});
            check("mem_cmd", {44'd0, mem_en, mem_we, mem_addr, (mem_we || !mem_en) ? mem_wdata : 8'h00},
                  {44'd0, prev_cmd});
            exp_h = '0; exp_f = '0; popped = 1'b0;
            while (ret_q.size() > 0 && ret_q[0].due == cycle) begin
                r = ret_q.pop_front();
                popped = 1'b1;
                if (r.host) exp_h = {1'b1, r.data};
                else        exp_f = {1'b1, r.data};
            end
            check("host_ret", {55'd0, host_rvalid, host_rdata}, {55'd0, exp_h});
            check("fch_ret", {55'd0, fch_rvalid, fch_rdata}, {55'd0, exp_f});
            check("busy", {63'd0, busy}, {63'd0, popped || (ret_q.size() > 0)});
            // Expected next command and returns come from the expected grants.
            cmd = '0;
            if (e_wg)                    cmd = {2'b11, w_addr, w_wdata};
            else if (e_hg)               cmd = {1'b1, h_we, h_addr, h_we ? h_wdata : 8'h00};
            else if (e_fg && f_addr != ZP) cmd = {2'b10, f_addr, 8'h00};
            prev_cmd = cmd;
            if (e_hg && !h_we) ret_q.push_back('{cycle + 2, 1'b1, shadow[h_addr]});
            if (e_fg) ret_q.push_back('{cycle + 2, 1'b0, (f_addr == ZP) ? 8'h00 : shadow[f_addr]});
            if (e_wg)               shadow[w_addr] = w_wdata;
            else if (e_hg && h_we)  shadow[h_addr] = h_wdata;
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle();
        step(0, 0, 0, 10'h0, 8'h0, 0, 10'h0, 0, 10'h0, 8'h0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 10'h0, 8'h0, 0, 10'h0, 0, 10'h0, 8'h0, 0, 0, 0);
    endtask

    initial begin
        clk = 0; reset = 1;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        fch_req = 0; fch_addr = '0; wb_req = 0; wb_addr = '0; wb_wdata = '0;
        mem_rdata = '0;
        cycle = 0; total = 0; bad = 0; prev_cmd = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end

        do_reset();
        do_reset();

        // Host write then read back.
        step(0, 1, 1, 10'h010, 8'h5A, 0, 10'h0, 0, 10'h0, 8'h0, 1, 0, 0);
        step(0, 1, 0, 10'h010, 8'h00, 0, 10'h0, 0, 10'h0, 8'h0, 1, 0, 0);
        idle(); idle(); idle();

        // Host vs fetch contention alternates starting with host.
        do_reset();
        for (int k = 0; k < 6; k++)
            step(0, 1, 0, 10'h040, 8'h0, 1, 10'h050, 0, 10'h0, 8'h0, (k % 2) == 0, (k % 2) == 1, 0);
        idle(); idle();

        // Writeback outranks both, round-robin untouched.
        do_reset();
        for (int k = 0; k < 3; k++)
            step(0, 1, 0, 10'h041, 8'h0, 1, 10'h051, 1, 10'(10'h060 + k), 8'(8'hC0 + k), 0, 0, 1);
        step(0, 1, 0, 10'h061, 8'h0, 1, 10'h062, 0, 10'h0, 8'h0, 1, 0, 0);
        step(0, 1, 0, 10'h061, 8'h0, 1, 10'h062, 0, 10'h0, 8'h0, 0, 1, 0);
        idle(); idle();

        // Zero-point fetch rides alongside a host read and alongside a writeback.
        step(0, 1, 0, 10'h020, 8'h0, 1, ZP, 0, 10'h0, 8'h0, 1, 1, 0);
        step(0, 0, 0, 10'h000, 8'h0, 1, ZP, 1, 10'h070, 8'h77, 0, 1, 1);
        idle(); idle();

        // Reset while a host read is in flight drops the return.
        step(0, 1, 0, 10'h010, 8'h0, 0, 10'h0, 0, 10'h0, 8'h0, 1, 0, 0);
        step(1, 1, 0, 10'h010, 8'h0, 1, 10'h050, 1, 10'h071, 8'h11, 0, 0, 0);
        idle(); idle(); idle();

        // Host starvation under continuous writeback.
        do_reset();
        for (int k = 0; k < 17; k++) begin
`ifdef MAT_ARB_STARVE_GUARD_EN
            step(0, 1, 1, 10'h030, 8'h33, 0, 10'h0, 1, 10'(10'h080 + k), 8'(k), k == 15, 0, k != 15);
`else
            step(0, 1, 1, 10'h030, 8'h33, 0, 10'h0, 1, 10'(10'h080 + k), 8'(k), 0, 0, 1);
`endif
        end
        idle(); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
